cmd_issuer: RTL and testbench
=============================

CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries; power of two, at least 2.
REQ-002 SHALL have i_clk  input  1  the single clock.
REQ-003 SHALL have i_rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have i_cmd_valid  input  1  upstream command offered.
REQ-005 SHALL have i_cmd  input  cmd_t  fields addr0, addr1, wr_addr (addr_t), op (2 bit), count (instr_info_t count width).
REQ-006 SHALL have o_cmd_ready  output  1  queue can accept; equals not full.
REQ-007 SHALL have o_en  output  1  processor enable, drives proc i_en.
REQ-008 SHALL have o_valid  output  1  instruction valid or finish ack, drives proc i_valid.
REQ-009 SHALL have o_instr  output  instr_t  instruction word, drives proc i_instr.
REQ-010 SHALL have i_busy and i_finish  input  1 each  processor o_busy and o_finish.
REQ-011 SHALL have o_done  output  1  one-cycle pulse per retired command.
REQ-012 SHALL have o_retired  output  16  count of retired commands; wraps 0xFFFF to 0.
REQ-013 SHALL have o_idle  output  1  high when queue is empty and FSM is in S_IDLE.

Function
REQ-014 Push SHALL occur when i_cmd_valid and o_cmd_ready are both high; pop SHALL occur on FSM leaving S_IDLE.
REQ-015 When push and pop occur in the same cycle, occupancy SHALL stay unchanged; push while full SHALL be impossible, because o_cmd_ready is low.
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from a log2(FIFO_DEPTH)+1 bit occupancy counter.
REQ-017 FSM states SHALL be S_IDLE, S_EN, S_LD1, S_LD2, S_INFO, S_STORE, S_WAIT, S_ACK.
REQ-018 S_IDLE: if queue is non-empty, !i_busy, and head count != 0 -> latch head, pop, go to S_EN; if head count == 0 -> pop, pulse o_done, stay in S_IDLE, no processor traffic.
REQ-019 S_EN: o_en=1 for exactly one cycle -> S_LD1.
REQ-020 S_LD1: o_valid=1, o_instr = {INSTR_LD, addr0} -> S_LD2.
REQ-021 S_LD2: o_valid=1, o_instr = {INSTR_LD, addr1} -> S_INFO.
REQ-022 S_INFO: o_valid=1, o_instr = {INSTR_INFO, op, count} -> S_STORE.
REQ-023 S_STORE: o_valid=1, o_instr = {INSTR_STORE, wr_addr} -> S_WAIT; each setup word SHALL be held valid for exactly one cycle.
REQ-024 S_WAIT: o_valid=0; on i_finish=1 -> S_ACK.
REQ-025 S_ACK: o_valid=1 with o_instr opcode not LD/INFO/STORE for one cycle; o_done pulses; o_retired increments -> S_IDLE.
REQ-026 Latency SHALL be: empty-queue push to first o_en = 2 cycles; o_en to STORE word = 4 cycles; i_finish to o_done = 1 cycle.
REQ-027 Outside S_EN, o_en SHALL be 0; outside S_LD1..S_STORE and S_ACK, o_valid SHALL be 0.
REQ-028 The queue SHALL keep accepting commands while the FSM is in any state.

Reset
REQ-029 With i_rst high at a clock edge, FSM SHALL go to S_IDLE and pointers/occupancy SHALL clear; queued commands SHALL be discarded.
REQ-030 During reset, o_en=0, o_valid=0, o_instr=0, o_done=0, o_retired=0, o_cmd_ready=0, and o_idle=1 SHALL hold.
REQ-031 Reset mid-operation, including in S_WAIT, SHALL abandon the command with no o_done; the processor SHALL be reset by the same system reset.

Structure
REQ-032 cmd_t, the issuer state enum, and FIFO_DEPTH default SHALL reside in a shared package; instr_t, addr_t, and the INSTR_* opcodes SHALL come from the existing defines.
REQ-033 The queue SHALL be a sub-module named cmd_fifo (synchronous, registered storage, single clock); the FSM and retire counter SHALL reside in cmd_issuer.

Verification
REQ-034 Single command {addr0=0x10, addr1=0x40, wr_addr=0x80, op=0, count=12} with a proc model: LD 0x10, LD 0x40, INFO(0,12), STORE 0x80 appear on consecutive cycles after o_en; on i_finish, ack follows, o_done=1, o_retired=1.
REQ-035 Push 5 commands back-to-back with DEPTH=4 and processor stalled: o_cmd_ready drops after 4 pushes; the 5th is accepted only after the first pop; issue order is preserved.
REQ-036 Command with count=0 between two count=5 commands: o_done pulses for all three; o_retired=3; o_en occurs exactly twice.
REQ-037 i_busy held high with queue non-empty: no o_en until i_busy falls; then o_en occurs the next cycle.
REQ-038 Assert i_rst in S_WAIT with 2 commands queued: next cycle o_idle=1, o_cmd_ready=1, o_retired=0, no o_done.
REQ-039 Retire 65537 commands (counter preloaded via force to 0xFFFE): o_retired wraps to 0, then 1.

Source files
------------

// File: rtl/cmd_issuer_pkg.sv
// Shared types for the command issuer: address/instruction words, the
// queued command record, issuer FSM states and the default queue depth.
package cmd_issuer_pkg;

    localparam int ADDR_W         = 8;
    localparam int COUNT_W        = 6;
    localparam int OPC_W          = 2;
    localparam int INSTR_W        = OPC_W + ADDR_W;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [COUNT_W-1:0] count_t;

    // Opcode field of instr_t; NOP doubles as the finish acknowledge word.
    localparam logic [OPC_W-1:0] INSTR_NOP   = 2'd0;
    localparam logic [OPC_W-1:0] INSTR_LD    = 2'd1;
    localparam logic [OPC_W-1:0] INSTR_INFO  = 2'd2;
    localparam logic [OPC_W-1:0] INSTR_STORE = 2'd3;

    typedef struct packed {
        addr_t       addr0;
        addr_t       addr1;
        addr_t       wr_addr;
        logic [1:0]  op;
        count_t      count;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EN    = 3'd1,
        S_LD1   = 3'd2,
        S_LD2   = 3'd3,
        S_INFO  = 3'd4,
        S_STORE = 3'd5,
        S_WAIT  = 3'd6,
        S_ACK   = 3'd7
    } state_t;

    // Build an instruction word from opcode and 8-bit payload.
    function automatic instr_t f_mk_instr(input logic [OPC_W-1:0] opc,
                                          input logic [ADDR_W-1:0] payload);
        return {opc, payload};
    endfunction

endpackage

// File: rtl/cmd_issuer_fifo.sv
// Single-clock command queue with registered storage. Full/empty come from
// an occupancy counter one bit wider than the pointers.
module cmd_fifo
    import cmd_issuer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    cmd_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage write; entries cleared on reset so the head never shows stale data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= cmd_t'({CMD_W{1'b0}});
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_issuer.sv
// Command issuer: queues upstream commands and replays each one to the
// processor as enable, LD, LD, INFO, STORE, then waits for finish and acks.
module cmd_issuer
    import cmd_issuer_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    input  cmd_t        i_cmd,
    output logic        o_cmd_ready,
    output logic        o_en,
    output logic        o_valid,
    output instr_t      o_instr,
    input  logic        i_busy,
    input  logic        i_finish,
    output logic        o_done,
    output logic [15:0] o_retired,
    output logic        o_idle
);

    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    cmd_t   w_head;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_latch;
    logic   w_zero_done;
    cmd_t   r_cmd;

    logic   w_en_nxt;
    logic   w_valid_nxt;
    instr_t w_instr_nxt;
    logic   w_done_nxt;

    logic        r_en;
    logic        r_valid;
    instr_t      r_instr;
    logic        r_done;
    logic [15:0] r_retired;

    assign o_cmd_ready = !w_full && !i_rst;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    assign o_en        = r_en;
    assign o_valid     = r_valid;
    assign o_instr     = r_instr;
    assign o_done      = r_done;
    assign o_retired   = r_retired;
    assign o_idle      = i_rst || (w_empty && (r_state == S_IDLE));

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state logic; zero-count commands retire straight from idle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_latch     = 1'b0;
        w_zero_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head.count == {COUNT_W{1'b0}}) begin
                        w_pop       = 1'b1;
                        w_zero_done = 1'b1;
                    end else if (!i_busy) begin
                        w_pop       = 1'b1;
                        w_latch     = 1'b1;
                        w_state_nxt = S_EN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EN:    w_state_nxt = S_LD1;
            S_LD1:   w_state_nxt = S_LD2;
            S_LD2:   w_state_nxt = S_INFO;
            S_INFO:  w_state_nxt = S_STORE;
            S_STORE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_finish) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        w_en_nxt    = 1'b0;
        w_valid_nxt = 1'b0;
        w_instr_nxt = {INSTR_W{1'b0}};
        w_done_nxt  = w_zero_done;
        case (w_state_nxt)
            S_EN: begin
                w_en_nxt = 1'b1;
            end
            S_LD1: begin
                w_valid_nxt = 1'b1;
                w_instr_nxt = f_mk_instr(INSTR_LD, r_cmd.addr0);
            end
            S_LD2: begin
                w_valid_nxt = 1'b1;
                w_instr_nxt = f_mk_instr(INSTR_LD, r_cmd.addr1);
            end
            S_INFO: begin
                w_valid_nxt = 1'b1;
                w_instr_nxt = f_mk_instr(INSTR_INFO, {r_cmd.op, r_cmd.count});
            end
            S_STORE: begin
                w_valid_nxt = 1'b1;
                w_instr_nxt = f_mk_instr(INSTR_STORE, r_cmd.wr_addr);
            end
            S_ACK: begin
                w_valid_nxt = 1'b1;
                w_instr_nxt = f_mk_instr(INSTR_NOP, {ADDR_W{1'b0}});
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_en_nxt = 1'b0;
            end
        endcase
    end

    // State register and latched head command.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cmd   <= cmd_t'({CMD_W{1'b0}});
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_cmd <= w_head;
            end
        end
    end

    // Registered processor-facing outputs, done pulse and retire counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en      <= 1'b0;
            r_valid   <= 1'b0;
            r_instr   <= {INSTR_W{1'b0}};
            r_done    <= 1'b0;
            r_retired <= 16'h0000;
        end else begin
            r_en    <= w_en_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_done  <= w_done_nxt;
            if (w_done_nxt) begin
                r_retired <= r_retired + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed testbench for cmd_issuer with a small processor model that
// raises finish a few cycles after each STORE word.
module tb_cmd_issuer;
    import cmd_issuer_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    cmd_t        cmd;
    logic        cmd_ready;
    logic        en;
    logic        valid;
    instr_t      instr;
    logic        busy;
    logic        finish;
    logic        done;
    logic [15:0] retired;
    logic        idle;

    int tests_run    = 0;
    int tests_failed = 0;

    // processor model / monitor state
    logic       proc_auto;
    int         fin_cnt;
    int         en_cnt   = 0;
    int         done_cnt = 0;
    logic [7:0] store_q [$];

    cmd_issuer #(.FIFO_DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .i_cmd       (cmd),
        .o_cmd_ready (cmd_ready),
        .o_en        (en),
        .o_valid     (valid),
        .o_instr     (instr),
        .i_busy      (busy),
        .i_finish    (finish),
        .o_done      (done),
        .o_retired   (retired),
        .o_idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor model: finish pulses one cycle, three cycles after the STORE word.
    always @(posedge clk) begin
        if (rst || !proc_auto) begin
            finish  <= 1'b0;
            fin_cnt <= 0;
        end else if (valid && instr[9:8] == INSTR_STORE) begin
            finish  <= 1'b0;
            fin_cnt <= 3;
        end else if (fin_cnt == 1) begin
            finish  <= 1'b1;
            fin_cnt <= 0;
        end else begin
            finish <= 1'b0;
            if (fin_cnt > 1) fin_cnt <= fin_cnt - 1;
        end
    end

    // Monitor: counts enables/dones and records STORE addresses in issue order.
    always @(negedge clk) begin
        if (en) en_cnt = en_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (valid && instr[9:8] == INSTR_STORE) store_q.push_back(instr[7:0]);
    end

    function automatic cmd_t mk(input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] wa, input logic [1:0] op,
                                input logic [5:0] cnt);
        cmd_t c;
        c.addr0   = a0;
        c.addr1   = a1;
        c.wr_addr = wa;
        c.op      = op;
        c.count   = cnt;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Push one command; returns one step after the accepting edge.
    task automatic push_cmd(input cmd_t c, output bit ok);
        ok = 1'b0;
        cmd = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            at_neg();
            if (cmd_ready) ok = 1'b1;
            tick();
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        at_neg();
        tests_run++;
        if ({en, valid, instr, done, retired, cmd_ready, idle} !==
            {1'b0, 1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_outputs: en=%b valid=%b instr=%h done=%b retired=%h ready=%b idle=%b required 0 0 000 0 0000 0 1",
                     en, valid, instr, done, retired, cmd_ready, idle);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        bit fin_prev;
        bit found;
        bit early;
        instr_t exp_w [4];
        exp_w = '{10'h110, 10'h140, 10'h20C, 10'h380};
        do_reset();
        proc_auto = 1'b1;
        push_cmd(mk(8'h10, 8'h40, 8'h80, 2'd0, 6'd12), ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_push: accepted=%b required 1", ok);
        end
        at_neg();
        tests_run++;
        if (en !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_en_early: en=%b required 0", en);
        end
        tick();
        at_neg();
        tests_run++;
        if ({en, valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_en_latency: en,valid=%b required 10", {en, valid});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            at_neg();
            tests_run++;
            if ({en, valid, instr} !== {1'b0, 1'b1, exp_w[k]}) begin
                tests_failed++;
                $display("FAIL single_word%0d: en=%b valid=%b instr=%h required 0 1 %h",
                         k, en, valid, instr, exp_w[k]);
            end
        end
        tick();
        at_neg();
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_wait_valid: valid=%b required 0", valid);
        end
        fin_prev = 1'b0;
        found = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (fin_prev) begin
                found = 1'b1;
                tests_run++;
                if ({done, valid, instr, retired} !== {1'b1, 1'b1, 10'h000, 16'h0001}) begin
                    tests_failed++;
                    $display("FAIL single_ack: done=%b valid=%b instr=%h retired=%h required 1 1 000 0001",
                             done, valid, instr, retired);
                end
            end else begin
                if (done) early = 1'b1;
                fin_prev = finish;
                tick();
                at_neg();
            end
        end
        tests_run++;
        if (!found || early) begin
            tests_failed++;
            $display("FAIL single_finish: seen=%b early_done=%b required 1 0", found, early);
        end
        tick();
        tick();
        at_neg();
        tests_run++;
        if ({done, idle} !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_after: done=%b idle=%b required 0 1", done, idle);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n_ok;
        int base_q;
        int base_d;
        bit still_full;
        logic [7:0] wa [5];
        wa = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        proc_auto = 1'b1;
        busy = 1'b1;
        base_q = store_q.size();
        base_d = done_cnt;
        n_ok = 0;
        for (int k = 0; k < 4; k++) begin
            push_cmd(mk(8'h01, 8'h02, wa[k], 2'd1, 6'd5), ok);
            if (ok) n_ok++;
        end
        at_neg();
        tests_run++;
        if (n_ok != 4 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_full: accepted=%0d ready=%b required 4 0", n_ok, cmd_ready);
        end
        cmd = mk(8'h01, 8'h02, wa[4], 2'd1, 6'd5);
        cmd_valid = 1'b1;
        still_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            at_neg();
            if (cmd_ready !== 1'b0) still_full = 1'b0;
        end
        tests_run++;
        if (still_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_stall_ready: held_low=%b required 1", still_full);
        end
        busy = 1'b0;
        tick();
        at_neg();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_after_pop: ready=%b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        wait_done(base_d + 5, 300, ok);
        tests_run++;
        if (!ok || store_q.size() - base_q != 5) begin
            tests_failed++;
            $display("FAIL b2b_retire: done_ok=%b stores=%0d required 1 5", ok, store_q.size() - base_q);
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (store_q[base_q + k] !== wa[k]) begin
                    tests_failed++;
                    $display("FAIL b2b_order%0d: wr_addr=%h required %h", k, store_q[base_q + k], wa[k]);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        bit ok;
        int base_e;
        int base_d;
        do_reset();
        proc_auto = 1'b1;
        base_e = en_cnt;
        base_d = done_cnt;
        push_cmd(mk(8'h11, 8'h22, 8'h33, 2'd2, 6'd5), ok);
        push_cmd(mk(8'h44, 8'h55, 8'h66, 2'd2, 6'd0), ok);
        push_cmd(mk(8'h77, 8'h88, 8'h99, 2'd2, 6'd5), ok);
        wait_done(base_d + 3, 200, ok);
        repeat (5) tick();
        tests_run++;
        if (!ok || done_cnt - base_d != 3 || en_cnt - base_e != 2 || retired !== 16'd3) begin
            tests_failed++;
            $display("FAIL zero_count: dones=%0d ens=%0d retired=%0d required 3 2 3",
                     done_cnt - base_d, en_cnt - base_e, retired);
        end
    endtask

    task automatic test_busy();
        bit ok;
        bit en_seen;
        int base_d;
        do_reset();
        proc_auto = 1'b1;
        busy = 1'b1;
        base_d = done_cnt;
        push_cmd(mk(8'h05, 8'h06, 8'h07, 2'd3, 6'd1), ok);
        en_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            if (en) en_seen = 1'b1;
            tick();
        end
        tests_run++;
        if (en_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_hold: en_seen=%b required 0", en_seen);
        end
        busy = 1'b0;
        at_neg();
        tests_run++;
        if (en !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_fall_same: en=%b required 0", en);
        end
        tick();
        at_neg();
        tests_run++;
        if (en !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_fall_next: en=%b required 1", en);
        end
        tick();
        wait_done(base_d + 1, 50, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL busy_retire: done_ok=%b required 1", ok);
        end
    endtask

    task automatic test_reset_wait();
        bit ok;
        int base_e;
        int base_d;
        do_reset();
        proc_auto = 1'b1;
        base_d = done_cnt;
        push_cmd(mk(8'h00, 8'h00, 8'h00, 2'd0, 6'd0), ok);
        wait_done(base_d + 1, 20, ok);
        tests_run++;
        if (!ok || retired !== 16'd1) begin
            tests_failed++;
            $display("FAIL rstw_pre: done_ok=%b retired=%0d required 1 1", ok, retired);
        end
        proc_auto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_cmd(mk(8'h20, 8'h30, 8'(8'h40 + k), 2'd1, 6'd5), ok);
        end
        repeat (12) tick();
        at_neg();
        tests_run++;
        if ({valid, en, idle, cmd_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rstw_in_wait: valid=%b en=%b idle=%b ready=%b required 0 0 0 1",
                     valid, en, idle, cmd_ready);
        end
        base_e = en_cnt;
        base_d = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        tests_run++;
        if ({idle, cmd_ready, retired, done} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL rstw_after: idle=%b ready=%b retired=%h done=%b required 1 1 0000 0",
                     idle, cmd_ready, retired, done);
        end
        proc_auto = 1'b1;
        repeat (20) tick();
        tests_run++;
        if (done_cnt != base_d || en_cnt != base_e) begin
            tests_failed++;
            $display("FAIL rstw_discard: dones=%0d ens=%0d required 0 0",
                     done_cnt - base_d, en_cnt - base_e);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int base_d;
        logic [15:0] exp_r [3];
        exp_r = '{16'hFFFF, 16'h0000, 16'h0001};
        do_reset();
        proc_auto = 1'b1;
        force dut.r_retired = 16'hFFFE;
        tick();
        release dut.r_retired;
        at_neg();
        tests_run++;
        if (retired !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL wrap_preload: retired=%h required fffe", retired);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            base_d = done_cnt;
            push_cmd(mk(8'h00, 8'h00, 8'h00, 2'd0, 6'd0), ok);
            wait_done(base_d + 1, 20, ok);
            tests_run++;
            if (!ok || retired !== exp_r[k]) begin
                tests_failed++;
                $display("FAIL wrap_step%0d: done_ok=%b retired=%h required 1 %h", k, ok, retired, exp_r[k]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = mk(8'h00, 8'h00, 8'h00, 2'd0, 6'd0);
        busy = 1'b0;
        proc_auto = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_count();
        test_busy();
        test_reset_wait();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
